// File: rtl/dmem_arbiter_if.sv
// Request/response port of the data-memory arbiter: a valid/ready request
// channel carrying one memory access, plus a one-cycle response pulse.
interface dmem_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [2:0]  size;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Requester side (CPU LSU or DMA engine)
  modport master (
    output valid, addr, wdata, we, size,
    input  ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Arbiter side
  modport slave (
    input  valid, addr, wdata, we, size,
    output ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single data-memory port.
// Each accepted request runs IDLE -> ACCESS (one registered memory cycle)
// -> RESP (one-cycle response pulse on the owning port).
module dmem_arbiter #(
  parameter int A_WIDTH = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave r0,
  dmem_arbiter_if.slave r1,
  output logic [31:0]   mem_A,
  output logic [31:0]   mem_WD,
  output logic          mem_WE,
  output logic [2:0]    mem_MemSrc,
  input  logic [31:0]   mem_RD
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_reg, state_next;
  logic        last_grant_reg;
  logic        owner_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        we_reg;
  logic [2:0]  size_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic grant0, grant1;
  logic ready0, ready1;
  logic req_err;

  // Round-robin: a lone valid port wins; on a tie the port that did not win
  // last time is granted. Only valid, state and last_grant feed ready.
  assign grant0 = r0.valid && (!r1.valid || last_grant_reg);
  assign grant1 = r1.valid && (!r0.valid || !last_grant_reg);

  // Reject reserved size, misaligned half/word and addresses past the memory.
  assign req_err = (size_reg[1:0] == 2'b11)
                || (size_reg[1:0] == 2'b01 && addr_reg[0])
                || (size_reg[1:0] == 2'b10 && addr_reg[1:0] != 2'b00)
                || ((addr_reg >> A_WIDTH) != 32'd0);

  // Next-state, ready and memory-port drive; memory port is idle (all zero)
  // except during ACCESS, so a reset in ACCESS drops mem_WE at once.
  always_comb begin
    state_next = state_reg;
    ready0     = 1'b0;
    ready1     = 1'b0;
    mem_A      = 32'd0;
    mem_WD     = 32'd0;
    mem_WE     = 1'b0;
    mem_MemSrc = 3'd0;
    case (state_reg)
      IDLE: begin
        ready0 = rst_n && grant0;
        ready1 = rst_n && grant1;
        if (grant0 || grant1) state_next = ACCESS;
      end
      ACCESS: begin
        mem_A      = addr_reg;
        mem_WD     = wdata_reg;
        mem_WE     = we_reg && !req_err;
        mem_MemSrc = size_reg;
        state_next = RESP;
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, request latch on handshake and registered response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      we_reg         <= 1'b0;
      size_reg       <= 3'd0;
      rdata_reg      <= 32'd0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && (grant0 || grant1)) begin
        owner_reg      <= grant1;
        last_grant_reg <= grant1;
        if (grant1) begin
          addr_reg  <= r1.addr;
          wdata_reg <= r1.wdata;
          we_reg    <= r1.we;
          size_reg  <= r1.size;
        end else begin
          addr_reg  <= r0.addr;
          wdata_reg <= r0.wdata;
          we_reg    <= r0.we;
          size_reg  <= r0.size;
        end
      end
      if (state_reg == ACCESS) begin
        rdata_reg <= (!we_reg && !req_err) ? mem_RD : 32'd0;
        err_reg   <= req_err;
      end
    end
  end

  // Response outputs: only the owner sees the pulse and its payload.
  assign r0.ready     = ready0;
  assign r1.ready     = ready1;
  assign r0.rsp_valid = (state_reg == RESP) && !owner_reg;
  assign r1.rsp_valid = (state_reg == RESP) &&  owner_reg;
  assign r0.rsp_rdata = r0.rsp_valid ? rdata_reg : 32'd0;
  assign r1.rsp_rdata = r1.rsp_valid ? rdata_reg : 32'd0;
  assign r0.rsp_err   = r0.rsp_valid && err_reg;
  assign r1.rsp_err   = r1.rsp_valid && err_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory behind the port, directed
// scenarios followed by randomized single-port traffic against a
// byte-level reference model.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if p0();
  dmem_arbiter_if p1();

  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;
  logic [2:0]  mem_MemSrc;

  dmem_arbiter #(.A_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n), .r0(p0), .r1(p1),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
    .mem_MemSrc(mem_MemSrc), .mem_RD(mem_RD)
  );

  int checks = 0;
  int failures = 0;

  // Memory environment: 1 KiB, combinational read with size/sign handling.
  logic [7:0] mem [0:1023];
  logic [9:0] ma0, ma1, ma2, ma3;
  assign ma0 = mem_A[9:0];
  assign ma1 = ma0 + 10'd1;
  assign ma2 = ma0 + 10'd2;
  assign ma3 = ma0 + 10'd3;

  // Memory read port
  always_comb begin
    mem_RD = 32'd0;
    case (mem_MemSrc[1:0])
      2'd0: mem_RD = {{24{~mem_MemSrc[2] & mem[ma0][7]}}, mem[ma0]};
      2'd1: mem_RD = {{16{~mem_MemSrc[2] & mem[ma1][7]}}, mem[ma1], mem[ma0]};
      2'd2: mem_RD = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
      default: mem_RD = 32'd0;
    endcase
  end

  // Memory write port
  always @(posedge clk) begin
    if (mem_WE) begin
      mem[ma0] <= mem_WD[7:0];
      if (mem_MemSrc[1:0] != 2'd0) mem[ma1] <= mem_WD[15:8];
      if (mem_MemSrc[1:0] == 2'd2) begin
        mem[ma2] <= mem_WD[23:16];
        mem[ma3] <= mem_WD[31:24];
      end
    end
  end

  // Reference memory image kept by the bench
  logic [7:0] ref_mem [0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference access: byte count from size, alignment by modulo, range by compare.
  task automatic ref_access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                            input logic [2:0] size, output logic [31:0] rd, output logic err);
    int nb;
    int idx;
    longint v;
    nb = 1 << size[1:0];
    err = (size[1:0] == 2'd3) || ((a % 32'(nb)) != 32'd0) || (a >= 32'h0010_0000);
    rd = 32'd0;
    if (!err) begin
      v = 0;
      for (int i = 0; i < nb; i++) begin
        idx = int'((a + 32'(i)) & 32'h3FF);
        if (we) ref_mem[idx] = 8'(wd >> (8 * i));
        else    v += longint'(ref_mem[idx]) << (8 * i);
      end
      if (!we) begin
        if (!size[2] && nb < 4 && v >= (64'sd1 << (8 * nb - 1))) v -= (64'sd1 << (8 * nb));
        rd = v[31:0];
      end
    end
  endtask

  task automatic drive(input int port, input logic v, input logic [31:0] a,
                       input logic [31:0] wd, input logic we, input logic [2:0] size);
    if (port == 0) begin
      p0.valid = v; p0.addr = a; p0.wdata = wd; p0.we = we; p0.size = size;
    end else begin
      p1.valid = v; p1.addr = a; p1.wdata = wd; p1.we = we; p1.size = size;
    end
  endtask

  // One uncontended transaction; called at posedge+1 with the DUT idle.
  task automatic do_req(input int port, input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [2:0] size,
                        output logic [31:0] got_rd, output logic got_err);
    logic [31:0] exp_rd;
    logic        exp_err;
    ref_access(a, wd, we, size, exp_rd, exp_err);
    drive(port, 1'b1, a, wd, we, size);
    #1;
    chk("ready_own",   (port == 0) ? p0.ready : p1.ready, 32'd1);
    chk("ready_other", (port == 0) ? p1.ready : p0.ready, 32'd0);
    @(posedge clk); #1;
    drive(port, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    chk("acc_A",      mem_A, a);
    chk("acc_WD",     mem_WD, wd);
    chk("acc_WE",     mem_WE, {31'd0, we && !exp_err});
    chk("acc_src",    mem_MemSrc, {29'd0, size});
    chk("acc_ready",  {p0.ready, p1.ready}, 32'd0);
    chk("acc_rspv",   {p0.rsp_valid, p1.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rsp_valid_own",   (port == 0) ? p0.rsp_valid : p1.rsp_valid, 32'd1);
    chk("rsp_valid_other", (port == 0) ? p1.rsp_valid : p0.rsp_valid, 32'd0);
    got_rd  = (port == 0) ? p0.rsp_rdata : p1.rsp_rdata;
    got_err = (port == 0) ? p0.rsp_err : p1.rsp_err;
    chk("rsp_rdata", got_rd, exp_rd);
    chk("rsp_err",   {31'd0, got_err}, {31'd0, exp_err});
    $display("txn port=%0d we=%0d size=%0d addr=%h wdata=%h rdata=%h err=%0d",
             port, we, size, a, wd, got_rd, got_err);
    @(posedge clk); #1;
    chk("idle_rspv", {p0.rsp_valid, p1.rsp_valid}, 32'd0);
    chk("idle_memA", mem_A, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] ra;
    logic [2:0]  rs;
    drive(0, 1'b1, 32'd0, 32'd0, 1'b0, 3'd0);
    drive(1, 1'b1, 32'd0, 32'd0, 1'b0, 3'd0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;

    // Reset values, with both ports requesting
    #2;
    chk("rst_ready",  {p0.ready, p1.ready}, 32'd0);
    chk("rst_rspv",   {p0.rsp_valid, p1.rsp_valid}, 32'd0);
    chk("rst_err",    {p0.rsp_err, p1.rsp_err}, 32'd0);
    chk("rst_rdata0", p0.rsp_rdata, 32'd0);
    chk("rst_rdata1", p1.rsp_rdata, 32'd0);
    chk("rst_mem",    mem_A | mem_WD | {28'd0, mem_WE, mem_MemSrc}, 32'd0);
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clear the memory region through the arbiter
    for (int w = 0; w < 256; w++) do_req(w % 2, 32'(w * 4), 32'd0, 1'b1, 3'b010, rd, er);

    // Single word load
    do_req(1, 32'h100, 32'h4433_2211, 1'b1, 3'b010, rd, er);
    do_req(0, 32'h100, 32'd0, 1'b0, 3'b010, rd, er);
    chk("tp_word_load", rd, 32'h4433_2211);

    // Sign handling
    do_req(1, 32'h7, 32'h80, 1'b1, 3'b000, rd, er);
    do_req(0, 32'h7, 32'd0, 1'b0, 3'b000, rd, er);
    chk("tp_signed_byte", rd, 32'hFFFF_FF80);
    do_req(0, 32'h7, 32'd0, 1'b0, 3'b100, rd, er);
    chk("tp_unsigned_byte", rd, 32'h0000_0080);

    // Errors
    do_req(0, 32'h101, 32'h5555, 1'b1, 3'b001, rd, er);
    chk("tp_misaligned_err", {31'd0, er}, 32'd1);
    do_req(0, 32'h100, 32'd0, 1'b0, 3'b010, rd, er);
    chk("tp_mem_unchanged", rd, 32'h4433_2211);
    do_req(1, 32'h0010_0000, 32'd0, 1'b0, 3'b010, rd, er);
    chk("tp_range_err", {31'd0, er}, 32'd1);
    chk("tp_range_rdata", rd, 32'd0);
    do_req(0, 32'h100, 32'd0, 1'b0, 3'b011, rd, er);
    chk("tp_reserved_err", {31'd0, er}, 32'd1);

    // Store then load
    do_req(1, 32'h40, 32'hABCD, 1'b1, 3'b001, rd, er);
    chk("tp_store_rdata", rd, 32'd0);
    chk("tp_store_err", {31'd0, er}, 32'd0);
    do_req(0, 32'h40, 32'd0, 1'b0, 3'b101, rd, er);
    chk("tp_half_load", rd, 32'h0000_ABCD);

    // Reset during ACCESS drops the store
    drive(1, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b1, 3'b010);
    #1;
    chk("rst_acc_ready", {31'd0, p1.ready}, 32'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    chk("rst_acc_we_before", {31'd0, mem_WE}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_acc_we_after", {31'd0, mem_WE}, 32'd0);
    chk("rst_acc_memA", mem_A, 32'd0);
    drive(0, 1'b1, 32'h100, 32'd0, 1'b0, 3'b010);
    drive(1, 1'b1, 32'h40, 32'd0, 1'b0, 3'b010);
    #1;
    chk("rst_hold_ready", {p0.ready, p1.ready}, 32'd0);
    @(posedge clk); #1;
    chk("rst_no_rsp", {p0.rsp_valid, p1.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    #1;

    // Round-robin with both ports valid from reset release
    for (int c = 0; c < 12; c++) begin
      chk("rr_ready0", {31'd0, p0.ready}, {31'd0, c % 6 == 0});
      chk("rr_ready1", {31'd0, p1.ready}, {31'd0, c % 6 == 3});
      chk("rr_rspv0",  {31'd0, p0.rsp_valid}, {31'd0, c % 6 == 2});
      chk("rr_rspv1",  {31'd0, p1.rsp_valid}, {31'd0, c % 6 == 5});
      if (c % 6 == 2) chk("rr_rdata0", p0.rsp_rdata, 32'h4433_2211);
      if (c % 6 == 5) chk("rr_rdata1", p1.rsp_rdata, 32'h0000_ABCD);
      $display("rr cycle=%0d ready=%b%b rsp_valid=%b%b", c, p0.ready, p1.ready,
               p0.rsp_valid, p1.rsp_valid);
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    #1;
    @(posedge clk); #1;

    // The dropped store must not have reached memory
    do_req(0, 32'h20, 32'd0, 1'b0, 3'b010, rd, er);
    chk("rst_store_dropped", rd, 32'd0);

    // Randomized single-port traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) ra = $urandom | 32'h0010_0000;
      else ra = 32'($urandom_range(0, 1020));
      rs = 3'($urandom_range(0, 7));
      do_req(int'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 1)), rs, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the byte-addressed data memory. It shares the single memory port between the CPU load/store unit (port 0) and a DMA/program-loader engine (port 1) using valid/ready request handshakes and round-robin arbitration. Each granted request is sequenced as one registered memory access followed by a one-cycle response pulse. Misaligned, out-of-range and reserved-size requests are rejected without touching memory.

## Interface
- A_WIDTH, 20: memory byte-address width; the valid range is 0 .. 2**A_WIDTH-1.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rN_valid  in  1  request valid on port N (N = 0, 1).
- rN_ready  out  1  request accepted when rN_valid and rN_ready are both high on a rising edge.
- rN_addr  in  32  byte address.
- rN_wdata  in  32  store data, right-aligned.
- rN_we  in  1  1 = store, 0 = load.
- rN_size  in  3  bits [1:0]: 00 byte, 01 half, 10 word, 11 reserved. Bit [2]: unsigned load.
- rN_rsp_valid  out  1  one-cycle response pulse.
- rN_rsp_rdata  out  32  load data; 0 for stores and errors.
- rN_rsp_err  out  1  request rejected; qualified by rN_rsp_valid.
- mem_A  out  32  memory address.
- mem_WD  out  32  memory write data.
- mem_WE  out  1  memory write enable.
- mem_MemSrc  out  3  memory size/sign control; same encoding as rN_size.
- mem_RD  in  32  combinational memory read data.

## Operation
- States: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE
  - rN_ready = rN_valid and granted(N). At most one ready is high.
  - If only one port is valid, that port is granted.
  - If both are valid, the port not in last_grant wins.
  - On handshake, latch addr, wdata, we, size and owner, update last_grant, then go to ACCESS.
- last_grant resets to 1, so port 0 wins the first tie.
- Error check on the latched request, computed in ACCESS. A request is in error if any of these holds:
  - size[1:0] = 11;
  - half-word with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr[31:A_WIDTH] != 0.
- ACCESS
  - mem_A, mem_WD and mem_MemSrc are driven from the latched registers.
  - mem_WE = we and not error.
  - At the end of the cycle, capture the response data: mem_RD for a load with no error, otherwise 0.
  - Capture the error flag and go to RESP.
- RESP
  - Owner's rsp_valid = 1 for exactly one cycle, with the registered rdata/err.
  - The other port's rsp_valid stays 0. Go to IDLE.
- Outside ACCESS, mem_A, mem_WD, mem_WE and mem_MemSrc are all 0.
- No ready is asserted in ACCESS or RESP. Requesters hold their valid and payload until accepted.
- A request that is still valid after its acceptance is treated as a new request.

## Timing
- Reset values, asserted asynchronously while rst_n = 0:
  - All ready, rsp_valid, rsp_err and mem_WE are 0.
  - rsp_rdata and all mem_* outputs are 0.
  - last_grant = 1.
- Reset mid-operation: an in-flight request is dropped with no response. If asserted during ACCESS, mem_WE falls immediately.
- Handshake at edge E:
  - ACCESS is the cycle after E; the store commits at edge E+1.
  - rsp_valid is high in the cycle after E+1 (load-use latency of 2 cycles).
- Peak throughput is one access per 3 cycles; ready next rises in the cycle after the RESP cycle.
- Response data is registered; no combinational path from mem_RD to rsp_rdata.
- Ready depends combinationally on valid, state and last_grant only, never on addr, size or data.

## Test plan
- Single load: preload bytes 0x11,0x22,0x33,0x44 at 0x100. Issue a port-0 word load at 0x100.
  - ready in cycle 0; mem_A = 0x100 in cycle 1; r0_rsp_valid in cycle 2 with rdata = 0x44332211, err = 0.
- Sign handling: memory byte 0x80 at 0x7.
  - Signed byte load (size 000) -> 0xFFFFFF80.
  - Unsigned byte load (size 100) -> 0x00000080.
- Round-robin: port 0 and port 1 both valid continuously from reset.
  - Grants alternate 0,1,0,1 with 3-cycle spacing.
  - Each rsp_valid pulses only on its own port.
- Errors:
  - Half store at 0x101 -> err = 1, mem_WE never high, memory unchanged.
  - Word load at 0x0010_0000 (A_WIDTH = 20) -> err = 1, rdata = 0.
  - Size 011 -> err = 1.
- Reset in ACCESS: port 1 word store of 0xDEADBEEF to 0x20, with rst_n pulled low during ACCESS.
  - mem_WE drops asynchronously; no rsp_valid.
  - After release, port 0 wins the first tie.
- Store then load: port 1 half store of 0xABCD at 0x40, then a port 0 unsigned half load at 0x40.
  - Load returns 0x0000ABCD; the store response has rdata = 0, err = 0.
